ov7670_config_sequencer: RTL

// - Walks the OV7670 register config ROM from address 0 and issues each {reg,value} entry as one SCCB write.
// - Sits between the config ROM (upstream) and the SCCB master (downstream).
// - Honours ROM markers: 16'hFFFF = end of table, 16'hFFF0 = fixed delay, 16'hFExx = read entry (skipped).
// - Raises done when the table completes; the camera capture path is held off until then.

---
 rtl/ov7670_config_sequencer_if.sv | 26 ++
 rtl/ov7670_config_sequencer.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/ov7670_config_sequencer_if.sv
// Bus bundle between the OV7670 config sequencer, its register ROM and the SCCB master.
interface ov7670_config_sequencer_if;
  logic        start;
  logic [7:0]  rom_addr;
  logic        rom_clk_en;
  logic [15:0] rom_dout;
  logic [7:0]  sccb_id;
  logic [7:0]  sccb_addr;
  logic [7:0]  sccb_data;
  logic        sccb_start;
  logic        sccb_ready;
  logic        sccb_err;
  logic        busy;
  logic        done;
  logic        error;

  modport master (
    input  start, rom_dout, sccb_ready, sccb_err,
    output rom_addr, rom_clk_en, sccb_id, sccb_addr, sccb_data, sccb_start, busy, done, error
  );

  modport slave (
    output start, rom_dout, sccb_ready, sccb_err,
    input  rom_addr, rom_clk_en, sccb_id, sccb_addr, sccb_data, sccb_start, busy, done, error
  );
endinterface

// File: rtl/ov7670_config_sequencer.sv
// Walks the OV7670 register ROM and issues each entry as an SCCB write, honouring end/delay/skip markers.
// Define CFG_RETRY_EN to retry NACKed writes up to MAX_RETRY times before flagging error.
module ov7670_config_sequencer #(
  parameter logic [7:0] CAM_ID       = 8'h42,
  parameter int         DELAY_CYCLES = 250_000,
  parameter int         MAX_RETRY    = 3
) (
  input logic                       clk,
  input logic                       rst,
  ov7670_config_sequencer_if.master bus
);

  localparam int            DW         = (DELAY_CYCLES > 1) ? $clog2(DELAY_CYCLES) : 1;
  localparam logic [DW-1:0] DELAY_LOAD = DW'(DELAY_CYCLES - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_ROMWAIT, S_DECODE, S_SEND, S_ACKWAIT, S_WAITRDY, S_DELAY, S_FINISH
  } state_t;

  state_t        r_state, w_nextState;
  logic [7:0]    r_romAddr, w_romAddr;
  logic [7:0]    r_sccbAddr, w_sccbAddr;
  logic [7:0]    r_sccbData, w_sccbData;
  logic [DW-1:0] r_delay, w_delay;
  logic          r_done, w_done;
  logic          w_sccbStart;
  logic          w_advance;

`ifdef CFG_RETRY_EN
  localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  logic [RW-1:0] r_retry, w_retry;
  logic          r_error, w_error;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    w_romAddr   = r_romAddr;
    w_sccbAddr  = r_sccbAddr;
    w_sccbData  = r_sccbData;
    w_delay     = r_delay;
    w_done      = r_done;
    w_sccbStart = 1'b0;
    w_advance   = 1'b0;
`ifdef CFG_RETRY_EN
    w_retry     = r_retry;
    w_error     = r_error;
`endif
    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          w_done      = 1'b0;
          w_romAddr   = 8'd0;
          w_nextState = S_FETCH;
`ifdef CFG_RETRY_EN
          w_error     = 1'b0;
          w_retry     = '0;
`endif
        end
      end
      S_FETCH:   w_nextState = S_ROMWAIT;
      S_ROMWAIT: w_nextState = S_DECODE;
      S_DECODE: begin
        if (bus.rom_dout == 16'hFFFF) begin
          w_nextState = S_FINISH;
        end else if (bus.rom_dout == 16'hFFF0) begin
          w_delay     = DELAY_LOAD;
          w_nextState = S_DELAY;
        end else if (bus.rom_dout[15:8] == 8'hFE) begin
          w_advance = 1'b1;
        end else begin
          w_sccbAddr  = bus.rom_dout[15:8];
          w_sccbData  = bus.rom_dout[7:0];
          w_nextState = S_SEND;
        end
      end
      S_SEND: begin
        if (bus.sccb_ready) begin
          w_sccbStart = 1'b1;
          w_nextState = S_ACKWAIT;
        end
      end
      S_ACKWAIT: w_nextState = S_WAITRDY;
      S_WAITRDY: begin
        if (bus.sccb_ready) begin
`ifdef CFG_RETRY_EN
          if (!bus.sccb_err) begin
            w_advance = 1'b1;
          end else if (r_retry < RW'(MAX_RETRY)) begin
            w_retry     = r_retry + RW'(1);
            w_nextState = S_SEND;
          end else begin
            w_error     = 1'b1;
            w_nextState = S_IDLE;
          end
`else
          w_advance = 1'b1;
`endif
        end
      end
      S_DELAY: begin
        if (r_delay == '0) w_advance = 1'b1;
        else               w_delay   = r_delay - DW'(1);
      end
      S_FINISH: begin
        w_done      = 1'b1;
        w_nextState = S_IDLE;
      end
      default: w_nextState = S_IDLE;
    endcase

    // The last ROM slot finishes the pass instead of wrapping back to address 0.
    if (w_advance) begin
`ifdef CFG_RETRY_EN
      w_retry = '0;
`endif
      if (r_romAddr == 8'hFF) begin
        w_nextState = S_FINISH;
      end else begin
        w_romAddr   = r_romAddr + 8'd1;
        w_nextState = S_FETCH;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_romAddr  <= 8'd0;
      r_sccbAddr <= 8'd0;
      r_sccbData <= 8'd0;
      r_delay    <= '0;
      r_done     <= 1'b0;
`ifdef CFG_RETRY_EN
      r_retry    <= '0;
      r_error    <= 1'b0;
`endif
    end else begin
      r_romAddr  <= w_romAddr;
      r_sccbAddr <= w_sccbAddr;
      r_sccbData <= w_sccbData;
      r_delay    <= w_delay;
      r_done     <= w_done;
`ifdef CFG_RETRY_EN
      r_retry    <= w_retry;
      r_error    <= w_error;
`endif
    end
  end

  assign bus.rom_addr   = r_romAddr;
  assign bus.rom_clk_en = (r_state == S_FETCH);
  assign bus.sccb_id    = CAM_ID;
  assign bus.sccb_addr  = r_sccbAddr;
  assign bus.sccb_data  = r_sccbData;
  assign bus.sccb_start = w_sccbStart;
  assign bus.busy       = (r_state != S_IDLE);
  assign bus.done       = r_done;
`ifdef CFG_RETRY_EN
  assign bus.error      = r_error;
`else
  assign bus.error      = 1'b0;
`endif

endmodule
